// File: rtl/postfix_pkg.sv
// Shared definitions for the postfix evaluator: token codes, FSM states,
// result error codes and the latched arithmetic operator.
package postfix_pkg;

  // ASCII codes carried on tok_data when tok_is_op=1
  localparam int TOK_ADD  = 43;
  localparam int TOK_SUB  = 45;
  localparam int TOK_MUL  = 42;
  localparam int TOK_END  = 36;
  localparam int TOK_LPAR = 40;
  localparam int TOK_RPAR = 41;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_EXEC  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_UNDER     = 2'd1,
    ERR_OVER      = 2'd2,
    ERR_MALFORMED = 2'd3
  } err_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } op_e;

endpackage

// File: rtl/eval_stack.sv
// Operand stack for the postfix evaluator. Supports push, pop-two-push-one
// (the binary-operator reduction) and clear. sp counts valid entries, so
// stack[sp-1] is the top and stack[sp-2] the next-to-top.
module eval_stack #(
  parameter int N     = 8,
  parameter int DEPTH = 16
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       push_i,
  input  logic                       pop2_i,
  input  logic                       clear_i,
  input  logic [N-1:0]               wdata_i,
  output logic [N-1:0]               top_o,
  output logic [N-1:0]               nxt_o,
  output logic [$clog2(DEPTH):0]     sp_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int IW  = $clog2(DEPTH);
  localparam int SPW = IW + 1;

  logic [N-1:0]   mem_q [DEPTH];
  logic [SPW-1:0] sp_q, sp_d;
  logic [IW-1:0]  top_idx, nxt_idx, push_idx;

  // Index arithmetic wraps when the stack is shallow; callers only use
  // top/nxt when enough entries are present.
  assign push_idx = IW'(sp_q);
  assign top_idx  = IW'(sp_q - SPW'(1));
  assign nxt_idx  = IW'(sp_q - SPW'(2));

  assign top_o   = mem_q[top_idx];
  assign nxt_o   = mem_q[nxt_idx];
  assign sp_o    = sp_q;
  assign full_o  = (sp_q == SPW'(DEPTH));
  assign empty_o = (sp_q == '0);

  // Storage write: push lands at sp, a reduction overwrites next-to-top
  always_ff @(posedge CLK) begin
    if (push_i) begin
      mem_q[push_idx] <= wdata_i;
    end else if (pop2_i) begin
      mem_q[nxt_idx] <= wdata_i;
    end
  end

  // Next stack pointer: clear wins, then push, then reduction
  always_comb begin
    sp_d = sp_q;
    if (clear_i) begin
      sp_d = '0;
    end else if (push_i) begin
      sp_d = sp_q + SPW'(1);
    end else if (pop2_i) begin
      sp_d = sp_q - SPW'(1);
    end
  end

  // Stack pointer register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

endmodule

// File: rtl/postfix_evaluator.sv
// Postfix evaluator: consumes tagged tokens from the infix-to-postfix
// converter, evaluates them on an operand stack and returns one result or
// error code per '$'-terminated expression.
//
// Handshakes: a token moves when tok_valid && tok_ready on a rising edge;
// a result moves when res_valid && res_ready on a rising edge. Valid never
// depends on ready; tok_ready depends only on state (and is held low while
// RST is asserted); res_valid/res_data/res_error hold until taken.
module postfix_evaluator
  import postfix_pkg::*;
#(
  parameter int N     = 8,
  parameter int DEPTH = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         tok_valid,
  output logic         tok_ready,
  input  logic [N-1:0] tok_data,
  input  logic         tok_is_op,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_data,
  output logic [1:0]   res_error,
  output logic [1:0]   dbg_state
);

  localparam int SPW = $clog2(DEPTH) + 1;

  state_e         state_q, state_d;
  err_e           err_q, err_d;
  op_e            op_q, op_d;
  logic [N-1:0]   res_q, res_d;

  logic           push, pop2, clr;
  logic [N-1:0]   wdata, alu, top, nxt;
  logic [SPW-1:0] sp;
  logic           full, empty, under;
  logic           xfer;
  logic           is_arith, is_end, is_paren;
  op_e            tok_op;

  eval_stack #(.N(N), .DEPTH(DEPTH)) u_stack (
    .CLK     (CLK),
    .RST     (RST),
    .push_i  (push),
    .pop2_i  (pop2),
    .clear_i (clr),
    .wdata_i (wdata),
    .top_o   (top),
    .nxt_o   (nxt),
    .sp_o    (sp),
    .full_o  (full),
    .empty_o (empty)
  );

  assign tok_ready = !RST && ((state_q == S_RUN) || (state_q == S_FLUSH));
  assign xfer      = tok_valid && tok_ready;
  assign under     = empty || (sp == SPW'(1));
  assign res_valid = (state_q == S_DONE);
  assign res_data  = res_q;
  assign res_error = err_q;
  assign dbg_state = state_q;
  assign wdata     = pop2 ? alu : tok_data;

  // Operator decode of the incoming token
  always_comb begin
    tok_op   = OP_ADD;
    is_arith = 1'b0;
    is_end   = (tok_data == N'(TOK_END));
    is_paren = (tok_data == N'(TOK_LPAR)) || (tok_data == N'(TOK_RPAR));
    if (tok_data == N'(TOK_ADD)) begin
      tok_op   = OP_ADD;
      is_arith = 1'b1;
    end else if (tok_data == N'(TOK_SUB)) begin
      tok_op   = OP_SUB;
      is_arith = 1'b1;
    end else if (tok_data == N'(TOK_MUL)) begin
      tok_op   = OP_MUL;
      is_arith = 1'b1;
    end
  end

  // ALU: a = next-to-top, b = top, result wraps modulo 2^N
  always_comb begin
    unique case (op_q)
      OP_ADD:  alu = nxt + top;
      OP_SUB:  alu = nxt - top;
      default: alu = nxt * top;
    endcase
  end

  // Next-state and stack control
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    res_d   = res_q;
    op_d    = op_q;
    push    = 1'b0;
    pop2    = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (xfer) begin
          if (!tok_is_op) begin
            if (full) begin
              err_d   = ERR_OVER;
              state_d = S_FLUSH;
            end else begin
              push = 1'b1;
            end
          end else if (is_arith) begin
            if (under) begin
              err_d   = ERR_UNDER;
              state_d = S_FLUSH;
            end else begin
              op_d    = tok_op;
              state_d = S_EXEC;
            end
          end else if (is_end) begin
            if (sp == SPW'(1)) begin
              res_d = top;
            end else begin
              err_d = ERR_MALFORMED;
            end
            state_d = S_DONE;
          end else if (is_paren) begin
            // Parentheses surviving conversion mean an unbalanced group
            err_d   = ERR_MALFORMED;
            state_d = S_FLUSH;
          end else begin
            err_d   = ERR_MALFORMED;
            state_d = S_FLUSH;
          end
        end
      end
      S_EXEC: begin
        pop2    = 1'b1;
        state_d = S_RUN;
      end
      S_FLUSH: begin
        // Only the terminator ends the flush; the first error is retained
        if (xfer && tok_is_op && is_end) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          clr     = 1'b1;
          err_d   = ERR_NONE;
          res_d   = '0;
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // Control registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_RUN;
      err_q   <= ERR_NONE;
      op_q    <= OP_ADD;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_postfix_evaluator.sv
// Bench for postfix_evaluator: directed cases plus randomized expressions,
// checked by a scoreboard fed from a queue-based reference evaluator.
module tb_postfix_evaluator;
  import postfix_pkg::*;

  localparam int N     = 8;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic         op;
    logic [N-1:0] d;
  } tok_t;

  logic         CLK = 1'b0;
  logic         RST;
  logic         tok_valid;
  logic         tok_ready;
  logic [N-1:0] tok_data;
  logic         tok_is_op;
  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] res_data;
  logic [1:0]   res_error;
  logic [1:0]   dbg_state;

  logic [N+1:0] exp_q[$];
  tok_t         cur[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;
  int           t0      = 0;
  bit           mark_t0 = 1'b0;
  bit           gap_en  = 1'b0;
  int           rr_mode = 1;   // 0 hold low, 1 hold high, 2 random

  postfix_evaluator #(.N(N), .DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .tok_valid (tok_valid),
    .tok_ready (tok_ready),
    .tok_data  (tok_data),
    .tok_is_op (tok_is_op),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_error (res_error),
    .dbg_state (dbg_state)
  );

  // Clock and cycle counter
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Result-side ready driver
  always @(posedge CLK) begin
    #1;
    if (rr_mode == 0) res_ready = 1'b0;
    else if (rr_mode == 1) res_ready = 1'b1;
    else res_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference evaluator: plain queue stack, first error wins
  function automatic logic [N+1:0] model(input tok_t e[$]);
    longint st[$];
    longint a, b, r;
    foreach (e[i]) begin
      if (!e[i].op) begin
        if (st.size() == DEPTH) return {2'd2, N'(0)};
        st.push_back(longint'(e[i].d));
      end else if (e[i].d == N'(TOK_ADD) || e[i].d == N'(TOK_SUB) || e[i].d == N'(TOK_MUL)) begin
        if (st.size() < 2) return {2'd1, N'(0)};
        b = st.pop_back();
        a = st.pop_back();
        if (e[i].d == N'(TOK_ADD)) r = a + b;
        else if (e[i].d == N'(TOK_SUB)) r = a - b;
        else r = a * b;
        r = r & ((64'd1 << N) - 1);
        st.push_back(r);
      end else if (e[i].d == N'(TOK_END)) begin
        if (st.size() == 1) return {2'd0, N'(st[0])};
        return {2'd3, N'(0)};
      end else begin
        return {2'd3, N'(0)};
      end
    end
    return {2'd3, N'(0)};
  endfunction

  function automatic tok_t opnd(input int v);
    tok_t t;
    t.op = 1'b0;
    t.d  = N'(v);
    return t;
  endfunction

  function automatic tok_t opr(input int c);
    tok_t t;
    t.op = 1'b1;
    t.d  = N'(c);
    return t;
  endfunction

  function automatic int rand_arith();
    int k;
    k = $urandom_range(0, 2);
    if (k == 0) return TOK_ADD;
    if (k == 1) return TOK_SUB;
    return TOK_MUL;
  endfunction

  // Scoreboard monitor: pops an expectation on every result handshake
  always @(negedge CLK) begin
    logic [N+1:0] e;
    if (!RST && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got err=%0d data=%0d, expected no result", res_error, res_data);
      end else begin
        e = exp_q.pop_front();
        check("result_error", res_error, e[N+1:N]);
        check("result_data", res_data, e[N-1:0]);
      end
    end
  end

  // Driver: offer one token and hold it until it transfers
  task automatic send(input tok_t t);
    int waited = 0;
    if (gap_en) repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
    tok_valid = 1'b1;
    tok_is_op = t.op;
    tok_data  = t.d;
    @(negedge CLK);
    while (!tok_ready && waited < 100) begin
      waited++;
      @(negedge CLK);
    end
    if (!tok_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL token_timeout: tok_ready=0 after %0d cycles, expected 1", waited);
    end else if (mark_t0) begin
      t0 = cyc;
      mark_t0 = 1'b0;
    end
    @(posedge CLK);
    #1;
    tok_valid = 1'b0;
    tok_is_op = 1'($urandom);
    tok_data  = N'($urandom);
  endtask

  task automatic send_expr();
    exp_q.push_back(model(cur));
    foreach (cur[i]) send(cur[i]);
  endtask

  task automatic wait_drain();
    int n = 0;
    rr_mode = 1;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge CLK);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
    end
    #1;
  endtask

  // Well-formed random postfix expression
  task automatic gen_valid();
    int nops, have, depth;
    nops = $urandom_range(1, 6);
    have = 0;
    depth = 0;
    cur.delete();
    while (have < nops || depth > 1) begin
      if (have < nops && (depth < 2 || $urandom_range(0, 1) == 1)) begin
        cur.push_back(opnd($urandom_range(0, 255)));
        have++;
        depth++;
      end else begin
        cur.push_back(opr(rand_arith()));
        depth--;
      end
    end
    cur.push_back(opr(TOK_END));
  endtask

  // Arbitrary token soup, optionally preceded by a long operand run
  task automatic gen_random(input int pre);
    int len, k, c;
    cur.delete();
    for (int i = 0; i < pre; i++) cur.push_back(opnd($urandom_range(0, 255)));
    len = $urandom_range(0, 12);
    for (int i = 0; i < len; i++) begin
      k = $urandom_range(0, 9);
      if (k < 5) cur.push_back(opnd($urandom_range(0, 255)));
      else if (k < 8) cur.push_back(opr(rand_arith()));
      else if (k == 8) cur.push_back(opr($urandom_range(0, 1) ? TOK_LPAR : TOK_RPAR));
      else begin
        c = $urandom_range(0, 255);
        if (c == TOK_END) c = 0;
        cur.push_back(opr(c));
      end
    end
    cur.push_back(opr(TOK_END));
  endtask

  initial begin
    int t1, n;
    tok_t full_list[$];

    // Reset
    RST = 1'b1;
    tok_valid = 1'b0;
    tok_is_op = 1'b0;
    tok_data  = '0;
    res_ready = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_error", res_error, 0);
    check("rst_tok_ready", tok_ready, 0);
    check("rst_state", dbg_state, S_RUN);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    check("post_rst_tok_ready", tok_ready, 1);

    // 3 4 + 2 * $ : value and first-transfer-to-result latency
    cur = '{opnd(3), opnd(4), opr(TOK_ADD), opnd(2), opr(TOK_MUL), opr(TOK_END)};
    mark_t0 = 1'b1;
    send_expr();
    n = 0;
    while (!res_valid && n < 50) begin
      @(negedge CLK);
      n++;
    end
    t1 = cyc;
    check("latency_cycles", t1 - t0, 8);
    check("direct_3_4_add_2_mul", res_data, 14);
    wait_drain();

    // Directed expressions through the scoreboard
    cur = '{opnd(5), opnd(7), opr(TOK_SUB), opr(TOK_END)};        send_expr();
    cur = '{opnd(16), opnd(16), opr(TOK_MUL), opr(TOK_END)};      send_expr();
    cur = '{opr(TOK_ADD), opnd(1), opr(TOK_END)};                 send_expr();
    cur = '{opnd(2), opr(TOK_END)};                               send_expr();
    cur = '{opnd(3), opnd(4), opr(TOK_END)};                      send_expr();
    cur = '{opnd(3), opr(TOK_LPAR), opr(TOK_END)};                send_expr();
    cur = '{opnd(36), opnd(36), opr(TOK_SUB), opr(TOK_END)};      send_expr();
    wait_drain();

    // Overflow: 17 operands, flush keeps tok_ready high until '$'
    full_list.delete();
    for (int i = 0; i < 17; i++) full_list.push_back(opnd(i + 1));
    full_list.push_back(opnd(99));
    full_list.push_back(opr(TOK_RPAR));
    full_list.push_back(opr(TOK_END));
    exp_q.push_back(model(full_list));
    for (int i = 0; i < 17; i++) send(full_list[i]);
    @(negedge CLK);
    check("flush_tok_ready", tok_ready, 1);
    check("flush_state", dbg_state, S_FLUSH);
    @(posedge CLK);
    #1;
    for (int i = 17; i < 20; i++) begin
      send(full_list[i]);
      if (i < 19) check("flush_tok_ready_mid", tok_ready, 1);
    end
    wait_drain();

    // Result held while res_ready stays low
    rr_mode = 0;
    @(posedge CLK);
    #1;
    cur = '{opnd(6), opnd(7), opr(TOK_MUL), opr(TOK_END)};
    send_expr();
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("hold_res_valid", res_valid, 1);
      check("hold_res_data", res_data, 42);
      check("hold_res_error", res_error, 0);
      check("hold_tok_ready", tok_ready, 0);
    end
    wait_drain();

    // Asynchronous reset while in S_EXEC
    send(opnd(3));
    send(opnd(4));
    send(opr(TOK_ADD));
    check("pre_rst_state", dbg_state, S_EXEC);
    RST = 1'b1;
    #1;
    check("arst_res_valid", res_valid, 0);
    check("arst_res_data", res_data, 0);
    check("arst_res_error", res_error, 0);
    check("arst_tok_ready", tok_ready, 0);
    check("arst_state", dbg_state, S_RUN);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    cur = '{opnd(9), opr(TOK_END)};
    send_expr();
    wait_drain();

    // Randomized expressions with idle gaps and random res_ready
    gap_en  = 1'b1;
    rr_mode = 2;
    for (int i = 0; i < 60; i++) begin
      n = $urandom_range(0, 9);
      if (n < 5) gen_valid();
      else if (n < 8) gen_random(0);
      else gen_random($urandom_range(14, 18));
      send_expr();
    end
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/postfix_evaluator.md
# postfix_evaluator

Downstream consumer of the infix-to-postfix converter. Accepts the tagged postfix token stream one token per handshake, evaluates it on an internal operand stack, and returns one N-bit result or an error code per expression. The `$` terminator closes each expression. The block then clears itself for the next expression.

## Interface
Parameters:
- N, 8, token and data width in bits.
- DEPTH, 16, operand stack depth in entries (power of two, at least 2).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous and active-high.
- tok_valid  in  1  token present on tok_data/tok_is_op.
- tok_ready  out  1  block can take a token this cycle.
- tok_data  in  N  operand value, or ASCII operator code.
- tok_is_op  in  1  0 means operand, 1 means operator or terminator (the converter's tag plane).
- res_valid  out  1  result/error available.
- res_ready  in  1  consumer takes result.
- res_data  out  N  expression value; 0 when res_error≠0.
- res_error  out  2  0 ok, 1 underflow, 2 overflow, 3 malformed.

## Operation
- A token transfers on a cycle where tok_valid && tok_ready.
- States: S_RUN, S_EXEC, S_FLUSH, S_DONE.
- tok_ready is asserted in S_RUN and S_FLUSH only.

S_RUN:
- Operand with sp<DEPTH: push; sp+1.
- Operand with sp==DEPTH: record error 2; go to S_FLUSH.
- `+`(43), `-`(45) or `*`(42) with sp≥2: latch the operator; go to S_EXEC.
- `+`, `-` or `*` with sp<2: record error 1; go to S_FLUSH.
- `$`(36) with sp==1: result = stack[0]; go to S_DONE.
- `$` with sp≠1: record error 3; go to S_DONE.
- Any other operator code, including `(` and `)`: record error 3; go to S_FLUSH.

S_EXEC (one cycle):
- Operands are a = stack[sp-2] and b = stack[sp-1].
- Write a op b to stack[sp-2]; sp-1; return to S_RUN.

S_FLUSH:
- Discard tokens until a `$` transfers, then go to S_DONE.
- The first recorded error is kept.

S_DONE:
- Hold res_valid=1, res_data and res_error stable until res_ready=1.
- On that edge: res_valid→0, res_error→0, sp→0, go to S_RUN.

Arithmetic, all modulo 2^N:
- `+` is a+b.
- `-` is a−b (two's complement).
- `*` is the low N bits of a·b.
- No overflow flag is produced for arithmetic.

## Timing
- Reset values: state S_RUN, sp 0, res_valid 0, res_data 0, res_error 0, tok_ready 0 while RST is high, stack contents don't-care.
- Reset mid-expression aborts the expression immediately, with no result emitted.
- Throughput: operand 1 cycle; operator 2 cycles (accept plus S_EXEC); `$` 1 cycle.
- Latency: res_valid rises on the edge after the `$` transfer.
- A result can be consumed on the same cycle it appears if res_ready=1.
- The first token of the next expression is accepted no earlier than the cycle after the result handshake.
- tok_ready is a function of state only; it is independent of tok_valid and res_ready.
- tok_data and tok_is_op are sampled only on a transfer. Data outside transfers is ignored.

## Structure
Shared package postfix_pkg contains:
- Token codes: TOK_ADD=43, TOK_SUB=45, TOK_MUL=42, TOK_END=36, TOK_LPAR=40, TOK_RPAR=41.
- The state enum.
- The error enum: ERR_NONE, ERR_UNDER, ERR_OVER, ERR_MALFORMED.

Sub-module eval_stack (N, DEPTH):
- Holds the register array and sp.
- Operations: push, pop-two-push-one, clear.
- Exposes top, next-to-top, sp, full, empty.
- The FSM and ALU live in postfix_evaluator.

## Test plan
- `3 4 + 2 * $`, res_ready=1 → res_data=14, res_error=0; total 8 cycles from the first transfer to res_valid.
- `5 7 - $` with N=8 → res_data=254; `16 16 * $` → res_data=0 (wrap).
- `+ 1 $` → res_error=1, res_data=0; the `1` is flushed; the next expression `2 $` returns 2.
- 17 operands then `$` with DEPTH=16 → res_error=2 after the `$`; tok_ready stays high during the flush.
- `3 4 $` → res_error=3.
- `3 ( $` → res_error=3.
- res_ready held low for 5 cycles → result stable and tok_ready=0 throughout.
- RST asserted during S_EXEC → all outputs zero asynchronously; the subsequent `9 $` returns 9.
